// File: rtl/iobus_pkg.sv
// iobus_pkg: shared definitions for the MCS IO bus decoder.
//   - FSM state encoding
//   - read data returned on a slave timeout
//   - slot field position in the master address and the per-slot window size
package iobus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } iobus_state_t;

  localparam logic [31:0] IOBUS_TIMEOUT_RDATA = 32'hDEAD_DEAD;

  localparam int SLOT_LSB     = 12;
  localparam int SLOT_MSB     = 15;
  localparam int WINDOW_BYTES = 1 << SLOT_LSB;
  localparam int OFFSET_W     = $clog2(WINDOW_BYTES);

endpackage

// File: rtl/iobus_decoder_if.sv
// iobus_decoder_if: bus bundle around the decoder.
//   m_* : MicroBlaze MCS IO bus master port (strobes, address, data, ready)
//   s_* : fan-out to NSLV peripheral slots (one-hot strobes, broadcast
//         offset/lanes/data, packed read data, per-slot ready)
// Modports:
//   slave  : the decoder (a slave of the MCS, driving the peripheral side)
//   master : the environment (MCS master plus peripheral models)
interface iobus_decoder_if
  import iobus_pkg::*;
#(
  parameter int NSLV = 4
);
  logic                m_addr_strobe;
  logic                m_read_strobe;
  logic                m_write_strobe;
  logic [31:0]         m_address;
  logic [3:0]          m_byte_enable;
  logic [31:0]         m_write_data;
  logic [31:0]         m_read_data;
  logic                m_ready;

  logic [NSLV-1:0]     s_addr_strobe;
  logic [NSLV-1:0]     s_read_strobe;
  logic [NSLV-1:0]     s_write_strobe;
  logic [OFFSET_W-1:0] s_address;
  logic [3:0]          s_byte_enable;
  logic [31:0]         s_write_data;
  logic [NSLV*32-1:0]  s_read_data;
  logic [NSLV-1:0]     s_ready;

  modport slave (
    input  m_addr_strobe, m_read_strobe, m_write_strobe, m_address,
           m_byte_enable, m_write_data,
    output m_read_data, m_ready,
    output s_addr_strobe, s_read_strobe, s_write_strobe, s_address,
           s_byte_enable, s_write_data,
    input  s_read_data, s_ready
  );

  modport master (
    output m_addr_strobe, m_read_strobe, m_write_strobe, m_address,
           m_byte_enable, m_write_data,
    input  m_read_data, m_ready,
    input  s_addr_strobe, s_read_strobe, s_write_strobe, s_address,
           s_byte_enable, s_write_data,
    output s_read_data, s_ready
  );
endinterface

// File: rtl/iobus_timeout_ctr.sv
// iobus_timeout_ctr: up-counter used to bound the wait for slave ready.
//   clk, rst  : clock, asynchronous active-low reset
//   clr       : synchronous clear (highest priority)
//   load      : synchronous load of load_val
//   load_val  : value taken on load
//   inc       : count enable
//   tc        : terminal count, high while count == TIMEOUT-1
module iobus_timeout_ctr #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/iobus_decoder.sv
// iobus_decoder: MCS IO bus address decoder with one registered forward stage.
//   clk, rst      : clock, asynchronous active-low reset
//   bus           : master-side and slave-side IO bus signals (slave modport)
//   err_clr       : synchronous clear of the sticky error flags
//   timeout_err   : sticky, a selected slave failed to ready in time
//   unmapped_err  : sticky, an address outside the slot windows was accessed
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for m_addr_strobe; latches the request and decodes it
// ST_FWD  | one cycle of strobes to the selected slot; clears the counter
// ST_WAIT | watching s_ready of the selected slot, bounded by TIMEOUT
// ST_RESP | one-cycle m_ready with the captured read data
module iobus_decoder
  import iobus_pkg::*;
#(
  parameter int          NSLV      = 4,
  parameter logic [31:0] BASE_ADDR = 32'hC000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            rst,
  iobus_decoder_if.slave  bus,
  input  logic            err_clr,
  output logic            timeout_err,
  output logic            unmapped_err
);

  iobus_state_t        state_q, state_d;
  logic [OFFSET_W-1:0] addr_q;
  logic [3:0]          be_q;
  logic [31:0]         wdata_q;
  logic                rd_q, wr_q;
  logic [3:0]          slot_q;
  logic [31:0]         rdata_q, rdata_d;
  logic                timeout_err_q, unmapped_err_q;

  logic                hit;
  logic                latch_en, rdata_en;
  logic                set_to, set_un;
  logic                ctr_clr, ctr_inc, ctr_tc;
  logic                sel_ready;
  logic [31:0]         sel_rdata;
  logic [NSLV-1:0]     as_vec, rs_vec, ws_vec;

  assign hit = (bus.m_address[31:16] == BASE_ADDR[31:16]) &&
               ({1'b0, bus.m_address[SLOT_MSB:SLOT_LSB]} < 5'(NSLV));

  // Only the latched slot's ready/data are visible to the FSM.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (slot_q == 4'(k)) begin
        sel_ready = bus.s_ready[k];
        sel_rdata = bus.s_read_data[32*k +: 32];
      end
    end
  end

  iobus_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (16)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr      (ctr_clr),
    .load     (1'b0),
    .load_val (16'd0),
    .inc      (ctr_inc),
    .tc       (ctr_tc)
  );

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    rdata_en = 1'b0;
    rdata_d  = '0;
    set_to   = 1'b0;
    set_un   = 1'b0;
    ctr_clr  = 1'b0;
    ctr_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.m_addr_strobe) begin
          latch_en = 1'b1;
          rdata_en = 1'b1;
          if (hit) begin
            state_d = ST_FWD;
          end else begin
            set_un  = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_FWD: begin
        ctr_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Ready takes priority over a coincident terminal count.
        if (sel_ready) begin
          rdata_en = 1'b1;
          rdata_d  = rd_q ? sel_rdata : 32'h0;
          state_d  = ST_RESP;
        end else if (ctr_tc) begin
          rdata_en = 1'b1;
          rdata_d  = rd_q ? IOBUS_TIMEOUT_RDATA : 32'h0;
          set_to   = 1'b1;
          state_d  = ST_RESP;
        end else begin
          ctr_inc = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      be_q           <= '0;
      wdata_q        <= '0;
      rd_q           <= 1'b0;
      wr_q           <= 1'b0;
      slot_q         <= '0;
      rdata_q        <= '0;
      timeout_err_q  <= 1'b0;
      unmapped_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        addr_q  <= bus.m_address[OFFSET_W-1:0];
        be_q    <= bus.m_byte_enable;
        wdata_q <= bus.m_write_data;
        rd_q    <= bus.m_read_strobe;
        wr_q    <= bus.m_write_strobe;
        slot_q  <= bus.m_address[SLOT_MSB:SLOT_LSB];
      end
      if (rdata_en) begin
        rdata_q <= rdata_d;
      end
      // A set in the same cycle as err_clr leaves the flag high.
      timeout_err_q  <= set_to | (timeout_err_q  & ~err_clr);
      unmapped_err_q <= set_un | (unmapped_err_q & ~err_clr);
    end
  end

  // Strobes decode from registered state only, so no master input reaches them combinationally.
  always_comb begin
    as_vec = '0;
    rs_vec = '0;
    ws_vec = '0;
    for (int k = 0; k < NSLV; k++) begin
      if ((state_q == ST_FWD) && (slot_q == 4'(k))) begin
        as_vec[k] = 1'b1;
        rs_vec[k] = rd_q;
        ws_vec[k] = wr_q;
      end
    end
  end

  assign bus.s_addr_strobe  = as_vec;
  assign bus.s_read_strobe  = rs_vec;
  assign bus.s_write_strobe = ws_vec;
  assign bus.s_address      = addr_q;
  assign bus.s_byte_enable  = be_q;
  assign bus.s_write_data   = wdata_q;
  assign bus.m_ready        = (state_q == ST_RESP);
  assign bus.m_read_data    = (state_q == ST_RESP) ? rdata_q : 32'h0;
  assign timeout_err        = timeout_err_q;
  assign unmapped_err       = unmapped_err_q;

endmodule

// File: tb/tb_iobus_decoder.sv
// tb_iobus_decoder: directed vector bench for iobus_decoder (NSLV=4, TIMEOUT=8).
// Each vector issues one master transaction, drives the selected slot's ready
// n cycles after the slave strobe, and checks strobes, latency, data and flags.
module tb_iobus_decoder;

  logic clk;
  logic rst;
  logic err_clr;
  logic timeout_err;
  logic unmapped_err;

  int n_vec = 0;
  int n_err = 0;

  iobus_decoder_if #(.NSLV(4)) bus ();

  iobus_decoder #(
    .NSLV      (4),
    .BASE_ADDR (32'hC000_0000),
    .TIMEOUT   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .err_clr      (err_clr),
    .timeout_err  (timeout_err),
    .unmapped_err (unmapped_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          rdy_n;      // ready at T+1+rdy_n; -1 = never
    logic [31:0] slv_data;
    logic        clr_at_strobe;
    logic        noise;      // stray s_ready[0] and m_addr_strobe during WAIT
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_as;
    logic        exp_un;
    logic        exp_to;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input int idx, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL v%0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  task automatic pulse_clr(input int idx);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk(idx, "clr_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk(idx, "clr_unmapped_err", {31'd0, unmapped_err}, 32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          lat;
    int          slot;
    logic [31:0] got;
    logic        stray;
    logic [127:0] rd;
    lat   = -1;
    got   = '0;
    stray = 1'b0;
    slot  = int'(v.addr[13:12]);
    for (int k = 0; k < 4; k++) rd[32*k +: 32] = 32'hBAD0_0000 + 32'(k);
    rd[32*slot +: 32] = v.slv_data;

    @(negedge clk);
    bus.s_read_data    = rd;
    bus.s_ready        = '0;
    bus.m_address      = v.addr;
    bus.m_read_strobe  = ~v.wr;
    bus.m_write_strobe = v.wr;
    bus.m_byte_enable  = v.be;
    bus.m_write_data   = v.wdata;
    bus.m_addr_strobe  = 1'b1;
    err_clr            = v.clr_at_strobe;

    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk(idx, "s_addr_strobe", {28'd0, bus.s_addr_strobe}, {28'd0, v.exp_as});
        chk(idx, "s_read_strobe", {28'd0, bus.s_read_strobe},
            {28'd0, (v.wr ? 4'b0000 : v.exp_as)});
        chk(idx, "s_write_strobe", {28'd0, bus.s_write_strobe},
            {28'd0, (v.wr ? v.exp_as : 4'b0000)});
        if (v.exp_as != 4'b0000) begin
          chk(idx, "s_address", {20'd0, bus.s_address}, {20'd0, v.addr[11:0]});
          chk(idx, "s_byte_enable", {28'd0, bus.s_byte_enable}, {28'd0, v.be});
          chk(idx, "s_write_data", bus.s_write_data, v.wdata);
        end
      end else if ((bus.s_addr_strobe | bus.s_read_strobe | bus.s_write_strobe) != 4'b0000) begin
        stray = 1'b1;
      end
      if (bus.m_ready) begin
        lat = c;
        got = bus.m_read_data;
      end
      bus.m_addr_strobe = 1'b0;
      err_clr           = 1'b0;
      bus.s_ready       = '0;
      if (v.rdy_n >= 0 && c == 1 + v.rdy_n) bus.s_ready[slot] = 1'b1;
      if (v.noise && c == 4) begin
        bus.s_ready[0]     = 1'b1;
        bus.m_addr_strobe  = 1'b1;
        bus.m_address      = 32'hC000_0000;
        bus.m_read_strobe  = 1'b1;
        bus.m_write_strobe = 1'b0;
      end
    end
    chk(idx, "m_ready_latency", 32'(lat), 32'(v.exp_lat));
    chk(idx, "m_read_data", got, v.exp_rdata);

    @(negedge clk);
    chk(idx, "m_read_data_after", bus.m_read_data, 32'h0);
    for (int c = 0; c < 2; c++) begin
      if (bus.m_ready || (bus.s_addr_strobe | bus.s_read_strobe | bus.s_write_strobe) != 4'b0000)
        stray = 1'b1;
      if (c == 0) @(negedge clk);
    end
    chk(idx, "stray_strobe_or_ready", {31'd0, stray}, 32'd0);
    chk(idx, "timeout_err", {31'd0, timeout_err}, {31'd0, v.exp_to});
    chk(idx, "unmapped_err", {31'd0, unmapped_err}, {31'd0, v.exp_un});
  endtask

  initial begin
    int   seen;
    vec_t post;

    vecs[0] = '{addr: 32'hC000_1000, wr: 1'b1, wdata: 32'hDEADBEEF, be: 4'hF, rdy_n: 1,
                slv_data: 32'h0101_0101, clr_at_strobe: 1'b0, noise: 1'b0,
                exp_lat: 3, exp_rdata: 32'h0, exp_as: 4'b0010, exp_un: 1'b0, exp_to: 1'b0};
    vecs[1] = '{addr: 32'hC000_0004, wr: 1'b0, wdata: 32'h0, be: 4'hF, rdy_n: 1,
                slv_data: 32'h1234_5678, clr_at_strobe: 1'b0, noise: 1'b0,
                exp_lat: 3, exp_rdata: 32'h1234_5678, exp_as: 4'b0001, exp_un: 1'b0, exp_to: 1'b0};
    vecs[2] = '{addr: 32'hC000_5000, wr: 1'b0, wdata: 32'h0, be: 4'hF, rdy_n: 0,
                slv_data: 32'h5555_5555, clr_at_strobe: 1'b0, noise: 1'b0,
                exp_lat: 1, exp_rdata: 32'h0, exp_as: 4'b0000, exp_un: 1'b1, exp_to: 1'b0};
    vecs[3] = '{addr: 32'h8000_0000, wr: 1'b0, wdata: 32'h0, be: 4'hF, rdy_n: 0,
                slv_data: 32'h6666_6666, clr_at_strobe: 1'b1, noise: 1'b0,
                exp_lat: 1, exp_rdata: 32'h0, exp_as: 4'b0000, exp_un: 1'b1, exp_to: 1'b0};
    vecs[4] = '{addr: 32'hC000_2000, wr: 1'b0, wdata: 32'h0, be: 4'hF, rdy_n: -1,
                slv_data: 32'h2222_2222, clr_at_strobe: 1'b0, noise: 1'b0,
                exp_lat: 10, exp_rdata: 32'hDEAD_DEAD, exp_as: 4'b0100, exp_un: 1'b0, exp_to: 1'b1};
    vecs[5] = '{addr: 32'hC000_3008, wr: 1'b0, wdata: 32'h0, be: 4'hF, rdy_n: 8,
                slv_data: 32'hA5A5_0003, clr_at_strobe: 1'b0, noise: 1'b1,
                exp_lat: 10, exp_rdata: 32'hA5A5_0003, exp_as: 4'b1000, exp_un: 1'b0, exp_to: 1'b0};
    vecs[6] = '{addr: 32'hC000_2010, wr: 1'b1, wdata: 32'hCAFE_F00D, be: 4'hF, rdy_n: -1,
                slv_data: 32'h2222_2222, clr_at_strobe: 1'b0, noise: 1'b0,
                exp_lat: 10, exp_rdata: 32'h0, exp_as: 4'b0100, exp_un: 1'b0, exp_to: 1'b1};
    vecs[7] = '{addr: 32'hC000_0020, wr: 1'b1, wdata: 32'h0000_BEEF, be: 4'b0011, rdy_n: 3,
                slv_data: 32'h7777_7777, clr_at_strobe: 1'b0, noise: 1'b0,
                exp_lat: 5, exp_rdata: 32'h0, exp_as: 4'b0001, exp_un: 1'b0, exp_to: 1'b1};

    rst                = 1'b0;
    err_clr            = 1'b0;
    bus.m_addr_strobe  = 1'b0;
    bus.m_read_strobe  = 1'b0;
    bus.m_write_strobe = 1'b0;
    bus.m_address      = '0;
    bus.m_byte_enable  = '0;
    bus.m_write_data   = '0;
    bus.s_read_data    = '0;
    bus.s_ready        = '0;

    repeat (3) @(negedge clk);
    chk(-1, "reset_m_ready", {31'd0, bus.m_ready}, 32'd0);
    chk(-1, "reset_m_read_data", bus.m_read_data, 32'd0);
    chk(-1, "reset_strobes", {20'd0, bus.s_addr_strobe, bus.s_read_strobe, bus.s_write_strobe}, 32'd0);
    chk(-1, "reset_flags", {30'd0, timeout_err, unmapped_err}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i]);
      if (i == 3 || i == 4) pulse_clr(i);
    end

    // Reset during WAIT: outputs drop at once, no m_ready follows.
    @(negedge clk);
    bus.s_ready        = '0;
    bus.m_address      = 32'hC000_1ABC;
    bus.m_read_strobe  = 1'b1;
    bus.m_write_strobe = 1'b0;
    bus.m_byte_enable  = 4'b1100;
    bus.m_write_data   = 32'h1357_9BDF;
    bus.m_addr_strobe  = 1'b1;
    @(negedge clk);
    bus.m_addr_strobe = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk(20, "async_rst_m_ready", {31'd0, bus.m_ready}, 32'd0);
    chk(20, "async_rst_s_address", {20'd0, bus.s_address}, 32'd0);
    chk(20, "async_rst_s_write_data", bus.s_write_data, 32'd0);
    chk(20, "async_rst_s_byte_enable", {28'd0, bus.s_byte_enable}, 32'd0);
    chk(20, "async_rst_flags", {30'd0, timeout_err, unmapped_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.m_ready || bus.s_addr_strobe != 4'b0000) seen++;
    end
    chk(20, "no_ready_after_reset", 32'(seen), 32'd0);

    post = '{addr: 32'hC000_1004, wr: 1'b0, wdata: 32'h0, be: 4'hF, rdy_n: 2,
             slv_data: 32'h1111_2222, clr_at_strobe: 1'b0, noise: 1'b0,
             exp_lat: 4, exp_rdata: 32'h1111_2222, exp_as: 4'b0010, exp_un: 1'b0, exp_to: 1'b0};
    run_vec(21, post);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iobus_decoder.md
Name: iobus_decoder

Overview:
- Sits between the MicroBlaze MCS IO bus master port and the peripheral IO modules (prng_iom and siblings).
- Decodes each transaction into a 4 KiB slave window and forwards strobes with a registered pipeline stage.
- Returns the selected slave's ready and read data to the master.
- Completes unmapped and stalled transactions itself, with error read data and sticky error flags.

Parameters:
- NSLV, 4, number of slave slots (1..16)
- BASE_ADDR, 32'hC000_0000, IO region base; only bits [31:16] are compared
- TIMEOUT, 255, cycles to wait for slave ready before forced completion (1..65535)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- m_addr_strobe  input  1  master transaction start
- m_read_strobe  input  1  master read qualifier
- m_write_strobe  input  1  master write qualifier
- m_address  input  32  master byte address
- m_byte_enable  input  4  master byte lanes
- m_write_data  input  32  master write data
- m_read_data  output  32  read data to master
- m_ready  output  1  one-cycle completion pulse to master
- s_addr_strobe  output  NSLV  per-slot addr strobe, one-hot
- s_read_strobe  output  NSLV  per-slot read strobe
- s_write_strobe  output  NSLV  per-slot write strobe
- s_address  output  12  broadcast offset, m_address[11:0]
- s_byte_enable  output  4  broadcast byte lanes
- s_write_data  output  32  broadcast write data
- s_read_data  input  NSLV*32  packed slave read data; slot k at [32k+31:32k]
- s_ready  input  NSLV  per-slot ready
- err_clr  input  1  synchronous clear of sticky errors
- timeout_err  output  1  sticky: a slave timed out
- unmapped_err  output  1  sticky: unmapped address was accessed

Behaviour:
- Reset (rst low, async):
  - state=IDLE; all outputs 0; timeout counter 0.
  - Reset asserted mid-transaction aborts it silently; no m_ready is issued.
- Decode:
  - hit = (m_address[31:16] == BASE_ADDR[31:16]) and (m_address[15:12] < NSLV).
  - slot = m_address[15:12].
- FSM states: IDLE, FWD, WAIT, RESP.
- IDLE:
  - On m_addr_strobe, latch address[11:0], byte_enable, write_data, read/write qualifiers and slot.
  - hit → FWD; miss → RESP with rdata=0 and unmapped_err set.
- FWD (exactly 1 cycle):
  - s_addr_strobe[slot]=1, plus s_read_strobe[slot] or s_write_strobe[slot] per the latched qualifier.
  - Other slots stay 0; then → WAIT with counter cleared.
- WAIT:
  - Monitor s_ready[slot] only; ready from other slots is ignored.
  - On s_ready[slot]: capture s_read_data slice (reads) or 0 (writes) → RESP.
  - Otherwise the counter increments. On counter == TIMEOUT-1 without ready: rdata=32'hDEAD_DEAD for reads, 0 for writes; timeout_err set; → RESP.
  - s_ready arriving on the same cycle as the timeout is treated as ready: no error, slave data returned.
- RESP (1 cycle):
  - m_ready=1 and m_read_data=captured value; → IDLE.
  - m_read_data returns to 0 on the next cycle.
- Latency:
  - Master strobe at cycle T → slave strobe at T+1.
  - Slave ready at T+1+n → m_ready at T+2+n.
  - Unmapped access: m_ready at T+1.
- Broadcast outputs (s_address, s_byte_enable, s_write_data) hold their latched values from FWD until the next transaction.
- m_addr_strobe outside IDLE: ignored; no state change and no error.
- Sticky errors:
  - err_clr clears both flags.
  - A set event in the same cycle as err_clr wins (flag stays 1).
- No combinational path from any master input to any slave strobe, or from s_ready to m_ready.

Decomposition:
- Shared package iobus_pkg:
  - FSM state encoding
  - IOBUS_TIMEOUT_RDATA = 32'hDEAD_DEAD
  - slot-field bit positions (SLOT_LSB = 12, SLOT_MSB = 15)
  - window size constant
- One natural sub-module, iobus_timeout_ctr: a loadable, clearable counter with a terminal-count flag, parameterised by TIMEOUT.

Test Plan:
- Write 32'hDEADBEEF to 32'hC000_1000 with a slot-1 model readying 1 cycle after its strobe:
  - s_write_strobe == 4'b0010 at T+1; s_write_data == 32'hDEADBEEF; m_ready at T+3.
  - timeout_err and unmapped_err remain 0.
- Read 32'hC000_0004 with slot 0 returning 32'h1234_5678:
  - s_address == 12'h004; m_read_data == 32'h1234_5678 on the m_ready cycle, 0 the next cycle.
- Read 32'hC000_5000 (slot 5 ≥ NSLV) and 32'h8000_0000:
  - m_ready at T+1 with data 0 each time; no s_* strobe; unmapped_err == 1.
  - Pulse err_clr → flag returns to 0.
- Read slot 2 that never readies, TIMEOUT=8:
  - m_ready exactly 10 cycles after the master strobe; m_read_data == 32'hDEAD_DEAD; timeout_err == 1.
- Slot 3 readies on the same cycle the counter hits TIMEOUT-1:
  - Real data is returned; timeout_err == 0.
  - While in WAIT, s_ready[0] pulses and a second m_addr_strobe arrives: both are ignored.
- Drive rst low during WAIT:
  - All outputs go to 0 asynchronously; no m_ready follows.
  - The next transaction after reset release completes normally.
